neuron_mac: RTL

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams N_INPUTS signed Q6.10 x/w pairs,
// adds the bias, rounds and saturates to a Q6.10 pre-activation result z.
module neuron_mac #(
    parameter int N_INPUTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        x_valid,
    input  logic [15:0] x,
    input  logic [15:0] w,
    output logic        x_ready,
    output logic        busy,
    output logic [15:0] z,
    output logic [3:0]  ctrl,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam logic [3:0] CTRL_EVAL = 4'b0011;
    localparam logic [3:0] CTRL_NONE = 4'b0000;
    localparam logic [8:0] LAST_IDX  = 9'(N_INPUTS - 1);

    // Accumulator plus bias, then round half toward +infinity back to Q6.10 scale.
    function automatic logic signed [39:0] round_sum(
        input logic signed [39:0] acc_v,
        input logic        [15:0] bias_v
    );
        logic signed [39:0] bias_ext;
        logic signed [39:0] sum;
        bias_ext  = $signed({{24{bias_v[15]}}, bias_v});
        sum       = acc_v + (bias_ext <<< 10);
        round_sum = (sum + 40'sd512) >>> 10;
    endfunction

    function automatic logic [15:0] sat16(input logic signed [39:0] v);
        if (v > 40'sd32767) begin
            sat16 = 16'h7FFF;
        end else if (v < -40'sd32768) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    state_e             state_q,   state_d;
    logic signed [39:0] acc_q,     acc_d;
    logic        [8:0]  cnt_q,     cnt_d;
    logic        [15:0] bias_q,    bias_d;
    logic        [15:0] z_q,       z_d;
    logic        [3:0]  ctrl_q,    ctrl_d;
    logic               done_q,    done_d;
    logic               x_ready_q, x_ready_d;
    logic               busy_q,    busy_d;
    logic signed [31:0] prod_s;

    // Full-precision Q12.20 product of the offered pair.
    always_comb begin
        prod_s = $signed(x) * $signed(w);
    end

    // Next-state and next-output logic of the evaluation FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        bias_d    = bias_q;
        z_d       = z_q;
        ctrl_d    = CTRL_NONE;
        done_d    = 1'b0;
        x_ready_d = x_ready_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bias_d    = bias;
                    acc_d     = 40'sd0;
                    cnt_d     = 9'd0;
                    state_d   = ACCUM;
                    x_ready_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    x_ready_d = 1'b0;
                    busy_d    = 1'b0;
                end
            end
            ACCUM: begin
                if (x_valid && x_ready_q) begin
                    acc_d = acc_q + {{8{prod_s[31]}}, prod_s};
                    cnt_d = cnt_q + 9'd1;
                    // Dropping x_ready on the final pair guarantees no extra pair slips in.
                    if (cnt_q == LAST_IDX) begin
                        state_d   = FINISH;
                        x_ready_d = 1'b0;
                    end else begin
                        state_d   = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            FINISH: begin
                z_d       = sat16(round_sum(acc_q, bias_q));
                ctrl_d    = CTRL_EVAL;
                done_d    = 1'b1;
                state_d   = IDLE;
                x_ready_d = 1'b0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                x_ready_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 40'sd0;
            cnt_q     <= 9'd0;
            bias_q    <= 16'h0000;
            z_q       <= 16'h0000;
            ctrl_q    <= CTRL_NONE;
            done_q    <= 1'b0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            bias_q    <= bias_d;
            z_q       <= z_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            x_ready_q <= x_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign x_ready = x_ready_q;
    assign busy    = busy_q;
    assign z       = z_q;
    assign ctrl    = ctrl_q;
    assign done    = done_q;

endmodule
